ppa_sub_pipe: RTL and testbench

- Pipelined 16-bit parallel-prefix subtractor (Sklansky tree), the inverse-direction companion to the team's combinational prefix adder.
- Computes diff = a - b - bin, plus a borrow-out and a zero flag.
- Splits the prefix tree across two register stages and carries a valid/ready handshake on both sides.
- Sits in datapaths that need a registered subtract/compare with backpressure, e.g. address-range checks and credit counters.

---
 rtl/ppa_pkg.sv | 16 +
 rtl/ppa_sklansky_rows.sv | 30 +++
 rtl/ppa_sub_pipe.sv | 63 ++++++
 tb/tb_ppa_sub_pipe.sv | 117 +++++++++++
 4 files changed

// File: rtl/ppa_pkg.sv
// ppa_pkg: shared prefix-network types, cell functions and default sizing for the ppa_* blocks
package ppa_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int LOG2W = $clog2(DEF_WIDTH);
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;
    typedef gp_t [DEF_WIDTH:0] gp_vec_t;
    function automatic gp_t ppa_black(input gp_t hi, input gp_t lo);
        return '{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};
    endfunction
    function automatic gp_t ppa_grey(input gp_t hi, input gp_t lo);
        return '{g: hi.g | (hi.p & lo.g), p: 1'b0};
    endfunction
endpackage

// File: rtl/ppa_sklansky_rows.sv
// ppa_sklansky_rows: combinational Sklansky rows FIRST..LAST over slots 0..WIDTH-1 (slot 0 = borrow, slot WIDTH passes through); x in, y out
module ppa_sklansky_rows
    import ppa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FIRST = 1,
    parameter int LAST  = 2
) (
    input  gp_t [WIDTH:0] x,
    output gp_t [WIDTH:0] y
);
    gp_t [WIDTH:0] row [LAST:FIRST-1];
    assign row[FIRST-1] = x;
    for (genvar r = FIRST; r <= LAST; r++) begin : g_row
        for (genvar k = 0; k <= WIDTH; k++) begin : g_col
            localparam int J = ((k >> (r - 1)) << (r - 1)) - 1;
            if (k < WIDTH && ((k >> (r - 1)) % 2) == 1) begin : g_cell
                // a span that now reaches slot 0 has absorbed the borrow term, so only g survives
                if (k < (1 << r)) begin : g_grey
                    assign row[r][k] = ppa_grey(row[r-1][k], row[r-1][J]);
                end else begin : g_black
                    assign row[r][k] = ppa_black(row[r-1][k], row[r-1][J]);
                end
            end else begin : g_pass
                assign row[r][k] = row[r-1][k];
            end
        end
    end
    assign y = row[LAST];
endmodule

// File: rtl/ppa_sub_pipe.sv
// ppa_sub_pipe: two-stage Sklansky subtractor diff = a - b - bin with bout/zero and valid/ready on both sides
module ppa_sub_pipe
    import ppa_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SPLIT_ROW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout,
    output logic             out_zero
);
    localparam int LW = $clog2(WIDTH);
    logic             s1_valid, s1_en, s2_en, bout;
    logic [WIDTH-1:0] s1_p, diff;
    gp_t  [WIDTH:0]   pre, mid, s1_gp, fin;
    assign s2_en    = ~out_valid | out_ready;
    assign s1_en    = ~s1_valid | s2_en;
    assign in_ready = s1_en;
    // a - b - bin is computed as a + ~b + ~bin, with ~bin living in slot 0
    always_comb begin
        pre[0] = '{g: ~in_bin, p: 1'b0};
        for (int i = 0; i < WIDTH; i++) pre[i+1] = '{g: in_a[i] & ~in_b[i], p: in_a[i] ^ ~in_b[i]};
    end
    ppa_sklansky_rows #(.WIDTH(WIDTH), .FIRST(1), .LAST(SPLIT_ROW)) u_rows_lo (.x(pre), .y(mid));
    ppa_sklansky_rows #(.WIDTH(WIDTH), .FIRST(SPLIT_ROW + 1), .LAST(LW)) u_rows_hi (.x(s1_gp), .y(fin));
    // slot i holds G[i-1:-1]; slot WIDTH is still the raw MSB g/p
    always_comb begin
        for (int i = 0; i < WIDTH; i++) diff[i] = s1_p[i] ^ fin[i].g;
        bout = ~(fin[WIDTH].g | (fin[WIDTH].p & fin[WIDTH-1].g));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_p      <= '0;
            s1_gp     <= '0;
            out_valid <= 1'b0;
            out_diff  <= '0;
            out_bout  <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            if (s1_en) s1_valid <= in_valid;
            if (s1_en && in_valid) begin
                s1_p  <= in_a ^ ~in_b;
                s1_gp <= mid;
            end
            if (s2_en) out_valid <= s1_valid;
            if (s2_en && s1_valid) begin
                out_diff <= diff;
                out_bout <= bout;
                out_zero <= (diff == '0);
            end
        end
    end
endmodule

// File: tb/tb_ppa_sub_pipe.sv
// tb_ppa_sub_pipe: randomized and directed check of ppa_sub_pipe against an arithmetic queue model
module tb_ppa_sub_pipe;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_bin = 1'b0;
    logic [15:0] in_a = '0, in_b = '0;
    logic        out_valid, out_ready = 1'b0, out_bout, out_zero;
    logic [15:0] out_diff;
    logic [17:0] q[$];
    int          nvec = 0, nerr = 0;
    logic [15:0] held;
    ppa_sub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_bin(in_bin), .out_valid(out_valid),
        .out_ready(out_ready), .out_diff(out_diff), .out_bout(out_bout), .out_zero(out_zero)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [17:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int unsigned ai, bs, d;
        ai = a;
        bs = b + bi;
        d  = (ai + 65536 - bs) % 65536;
        return {ai < bs, d == 0, 16'(d)};
    endfunction
    // drive one cycle at the negedge, then score any handshakes that the next posedge will complete
    task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b, input logic bi, input logic ordy);
        logic [17:0] e;
        in_valid  = iv;
        in_a      = iv ? a : 16'($urandom);
        in_b      = iv ? b : 16'($urandom);
        in_bin    = iv ? bi : 1'($urandom);
        out_ready = ordy;
        #1;
        if (out_valid) begin
            if (q.size() == 0) chk("spurious_out", 32'(out_valid), 0);
            else if (out_ready) begin
                e = q.pop_front();
                chk("diff", 32'(out_diff), 32'(e[15:0]));
                chk("bout", 32'(out_bout), 32'(e[17]));
                chk("zero", 32'(out_zero), 32'(e[16]));
            end
        end
        if (in_valid && in_ready) q.push_back(ref_sub(in_a, in_b, in_bin));
        @(negedge clk);
    endtask
    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("drain_empty", 32'(q.size()), 0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_diff", 32'(out_diff), 0);
        chk("rst_out_bout", 32'(out_bout), 0);
        chk("rst_out_zero", 32'(out_zero), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        step(1, 16'h0005, 16'h0003, 0, 1);
        chk("lat1_valid", 32'(out_valid), 0);
        step(0, 0, 0, 0, 1);
        chk("lat2_valid", 32'(out_valid), 1);
        chk("basic_diff", 32'(out_diff), 32'h0002);
        chk("basic_bout", 32'(out_bout), 0);
        chk("basic_zero", 32'(out_zero), 0);
        drain();
        step(1, 16'h0000, 16'h0001, 0, 1);
        step(1, 16'h8000, 16'h8000, 1, 1);
        step(1, 16'h1234, 16'h1234, 0, 1);
        step(1, 16'hFFFF, 16'h0000, 0, 1);
        step(1, 16'h0000, 16'hFFFF, 1, 1);
        drain();
        for (int i = 0; i < 100; i++) begin
            chk("stream_in_ready", 32'(in_ready), 1);
            step(1, 16'($urandom), 16'($urandom), 1'($urandom), 1);
        end
        drain();
        step(1, 16'h0100, 16'h0001, 0, 0);
        step(1, 16'h0200, 16'h0002, 1, 0);
        chk("bp_in_ready", 32'(in_ready), 0);
        held = out_diff;
        for (int i = 0; i < 4; i++) step(1, 16'h0300, 16'h0003, 0, 0);
        chk("bp_hold_diff", 32'(out_diff), 32'(held));
        chk("bp_queue", 32'(q.size()), 2);
        step(1, 16'h0300, 16'h0003, 0, 1);
        chk("bp_third_taken", 32'(q.size()), 2);
        drain();
        step(1, 16'h4000, 16'h0001, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("bubble_in_ready", 32'(in_ready), 1);
        chk("bubble_out_valid", 32'(out_valid), 1);
        step(1, 16'h5000, 16'h0002, 0, 0);
        chk("bubble_full", 32'(in_ready), 0);
        drain();
        step(1, 16'hAAAA, 16'h1111, 0, 0);
        step(1, 16'hBBBB, 16'h2222, 0, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_diff", 32'(out_diff), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
